// File: rtl/apb_csr_pkg.sv
// Shared definitions for the APB4 status/control CSR window.
package apb_csr_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned PROT_W = 3;
    localparam int unsigned WCNT_W = 4;

    localparam logic [ADDR_W-1:0] OFS_CTRL    = 12'h000;
    localparam logic [ADDR_W-1:0] OFS_STAT    = 12'h004;
    localparam logic [ADDR_W-1:0] OFS_SCRATCH = 12'h008;
    localparam logic [ADDR_W-1:0] OFS_ID      = 12'h00C;
    localparam logic [ADDR_W-1:0] OFS_LIMIT   = 12'h010;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Request fields captured in the SETUP phase.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [PROT_W-1:0] prot;
    } apb_req_t;

    // True for offsets that accept writes.
    function automatic logic is_rw_offset(input logic [ADDR_W-1:0] ofs);
        return (ofs == OFS_CTRL) || (ofs == OFS_SCRATCH);
    endfunction

endpackage

// File: rtl/apb_csr_bytereg.sv
// 32-bit register with per-byte write enables and a parameterised reset value.
module apb_csr_bytereg
    import apb_csr_pkg::*;
#(
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STRB_W-1:0] be,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Byte-lane update; lanes without an enable hold their value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (be[i]) begin
                    q[8*i +: 8] <= d[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/apb_csr_completer.sv
// APB4 completer for the status/control CSR window: CTRL, STAT, SCRATCH, ID.
module apb_csr_completer
    import apb_csr_pkg::*;
#(
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] CTRL_RST    = 32'h0000_0000,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hC0F1_6001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    input  logic [PROT_W-1:0] pprot,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [DATA_W-1:0] stat_rdata,
    output logic              stat_read,
    output logic [DATA_W-1:0] ctrl_q,
    output logic              ctrl_wr
);

    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    apb_req_t          req_q, req_d;

    logic              done;
    logic              err;
    logic              commit;
    logic              ctrl_wr_d;
    logic [STRB_W-1:0] ctrl_be;
    logic [STRB_W-1:0] scratch_be;
    logic [DATA_W-1:0] scratch_q;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_prot;

    // State, wait counter, latched request and the post-write CTRL pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            req_q   <= '0;
            ctrl_wr <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            req_q   <= req_d;
            ctrl_wr <= ctrl_wr_d;
        end
    end

    // Next-state logic: capture on SETUP, count wait states, leave on completion or abort.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    wcnt_d  = WCNT_LOAD;
                    req_d   = '{addr: paddr, write: pwrite, wdata: pwdata,
                                strb: pstrb, prot: pprot};
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else if (penable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion and error decode on the latched request.
    always_comb begin
        done   = (state_q == ACCESS) && psel && penable && (wcnt_q == '0);
        err    = (req_q.addr >= OFS_LIMIT)
              || (req_q.addr[1:0] != 2'b00)
              || (req_q.write && !is_rw_offset(req_q.addr))
              || (req_q.write && !req_q.prot[0]);
        commit = done && req_q.write && !err;
    end

    // Byte enables into the writable registers and the CTRL change notification.
    always_comb begin
        ctrl_be    = (commit && (req_q.addr == OFS_CTRL))    ? req_q.strb : '0;
        scratch_be = (commit && (req_q.addr == OFS_SCRATCH)) ? req_q.strb : '0;
        ctrl_wr_d  = commit && (req_q.addr == OFS_CTRL);
    end

    // Read mux; STAT passes the live status value through.
    always_comb begin
        rd_mux = '0;
        case (req_q.addr)
            OFS_CTRL:    rd_mux = ctrl_q;
            OFS_STAT:    rd_mux = stat_rdata;
            OFS_SCRATCH: rd_mux = scratch_q;
            OFS_ID:      rd_mux = ID_VALUE;
            default:     rd_mux = '0;
        endcase
    end

    // APB response and read-to-clear strobe, all qualified by completion.
    always_comb begin
        pready    = done;
        pslverr   = done && err;
        prdata    = (done && !req_q.write && !err) ? rd_mux : '0;
        stat_read = done && !req_q.write && !err && (req_q.addr == OFS_STAT);
    end

    assign unused_prot = ^req_q.prot[PROT_W-1:1];

    apb_csr_bytereg #(
        .RST_VAL(CTRL_RST)
    ) u_ctrl (
        .clk(clk),
        .rst(rst),
        .be (ctrl_be),
        .d  (req_q.wdata),
        .q  (ctrl_q)
    );

    apb_csr_bytereg #(
        .RST_VAL('0)
    ) u_scratch (
        .clk(clk),
        .rst(rst),
        .be (scratch_be),
        .d  (req_q.wdata),
        .q  (scratch_q)
    );

endmodule

// File: tb/tb_apb_csr_completer.sv
// Directed scoreboard bench for apb_csr_completer.
module tb_apb_csr_completer;
    import apb_csr_pkg::*;

    localparam int unsigned WAIT     = 1;
    localparam logic [31:0] CTRL_RST = 32'h1234_0000;
    localparam logic [31:0] ID_VAL   = 32'hC0F1_6001;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] stat_rdata;
    logic        stat_read;
    logic [31:0] ctrl_q;
    logic        ctrl_wr;

    int checks = 0;
    int errors = 0;
    int sread_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        sread;
        int          waits;
    } exp_t;
    exp_t sb[$];

    apb_csr_completer #(
        .WAIT_CYCLES(WAIT),
        .CTRL_RST   (CTRL_RST),
        .ID_VALUE   (ID_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pprot     (pprot),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .stat_rdata(stat_rdata),
        .stat_read (stat_read),
        .ctrl_q    (ctrl_q),
        .ctrl_wr   (ctrl_wr)
    );

    always #5 clk = ~clk;

    // Count read-to-clear strobes seen at clock edges.
    always @(posedge clk) begin
        if (stat_read === 1'b1) sread_cnt <= sread_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer starting at posedge+1; returns at posedge+1 after the completing edge.
    task automatic xfer(input string tag, input logic wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                        input logic [31:0] exp_rd, input logic exp_err, input logic exp_sread,
                        output logic wr_after, output logic wr_first);
        exp_t e;
        int   waits;
        int   s0;
        sb.push_back('{exp_rd, exp_err, exp_sread, int'(WAIT)});
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
        pwdata = wd; pstrb = st; pprot = pr;
        s0 = sread_cnt;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        wr_first = ctrl_wr;
        waits = 0;
        while (pready !== 1'b1 && waits < 20) begin
            @(posedge clk); #2;
            waits++;
        end
        e = sb.pop_front();
        check({tag, ".pready"}, 32'(pready), 32'(1'b1));
        check({tag, ".waits"}, 32'(waits), 32'(e.waits));
        if (!wr) check({tag, ".prdata"}, prdata, e.rdata);
        check({tag, ".pslverr"}, 32'(pslverr), 32'(e.err));
        check({tag, ".stat_read"}, 32'(stat_read), 32'(e.sread));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        wr_after = ctrl_wr;
        check({tag, ".sread_cnt"}, 32'(sread_cnt - s0), 32'(e.sread));
    endtask

    logic wa, wf;

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; stat_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst.pready", 32'(pready), 32'(1'b0));
        check("rst.pslverr", 32'(pslverr), 32'(1'b0));
        check("rst.prdata", prdata, 32'h0);
        check("rst.stat_read", 32'(stat_read), 32'(1'b0));
        check("rst.ctrl_wr", 32'(ctrl_wr), 32'(1'b0));
        check("rst.ctrl_q", ctrl_q, CTRL_RST);
        @(posedge clk); #1;

        xfer("id_rd", 1'b0, 12'h00C, 32'h0, 4'h0, 3'b001, ID_VAL, 1'b0, 1'b0, wa, wf);

        xfer("scr_wr", 1'b1, 12'h008, 32'hA5A5_5A5A, 4'b0101, 3'b001, 32'h0, 1'b0, 1'b0, wa, wf);
        check("scr_wr.ctrl_wr", 32'(wa), 32'(1'b0));
        xfer("scr_rd", 1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 32'h00A5_005A, 1'b0, 1'b0, wa, wf);
        check("scr.ctrl_q", ctrl_q, CTRL_RST);

        stat_rdata = 32'h0000_4C03;
        xfer("stat_rd", 1'b0, 12'h004, 32'h0, 4'hF, 3'b000, 32'h0000_4C03, 1'b0, 1'b1, wa, wf);

        xfer("err_wr_stat", 1'b1, 12'h004, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b1, 1'b0, wa, wf);
        xfer("err_rd_010", 1'b0, 12'h010, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, 1'b0, wa, wf);
        xfer("err_rd_002", 1'b0, 12'h002, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, 1'b0, wa, wf);
        xfer("err_wr_id", 1'b1, 12'h00C, 32'h0, 4'hF, 3'b001, 32'h0, 1'b1, 1'b0, wa, wf);
        xfer("err_unpriv", 1'b1, 12'h000, 32'h0000_0001, 4'hF, 3'b000, 32'h0, 1'b1, 1'b0, wa, wf);
        check("err_unpriv.ctrl_wr", 32'(wa), 32'(1'b0));
        check("err.ctrl_q", ctrl_q, CTRL_RST);

        xfer("ctrl_wr", 1'b1, 12'h000, 32'h0000_0001, 4'hF, 3'b001, 32'h0, 1'b0, 1'b0, wa, wf);
        check("ctrl_wr.pulse", 32'(wa), 32'(1'b1));
        check("ctrl_wr.ctrl_q", ctrl_q, 32'h0000_0001);
        xfer("ctrl_rd", 1'b0, 12'h000, 32'h0, 4'h0, 3'b001, 32'h0000_0001, 1'b0, 1'b0, wa, wf);
        check("ctrl_wr.pulse_len", 32'(wf), 32'(1'b0));

        xfer("ctrl_nostrb", 1'b1, 12'h000, 32'hFFFF_FFFF, 4'h0, 3'b001, 32'h0, 1'b0, 1'b0, wa, wf);
        check("ctrl_nostrb.pulse", 32'(wa), 32'(1'b1));
        check("ctrl_nostrb.ctrl_q", ctrl_q, 32'h0000_0001);

        // Reset lands during the wait state of a CTRL write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000;
        pwdata = 32'h0000_00FF; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst.pready", 32'(pready), 32'(1'b0));
        check("midrst.ctrl_q", ctrl_q, CTRL_RST);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst.idle_pready", 32'(pready), 32'(1'b0));
        check("midrst.ctrl_wr", 32'(ctrl_wr), 32'(1'b0));
        check("midrst.ctrl_q2", ctrl_q, CTRL_RST);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer("post_rst_rd", 1'b0, 12'h000, 32'h0, 4'h0, 3'b001, CTRL_RST, 1'b0, 1'b0, wa, wf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
